gpu_vertex_loader: RTL and testbench

Parametrised vertex register file between the command parser and the rasterizer setup. It loads coordinate, colour and UV words for up to NUM_VTX vertices. Target slots are tracked automatically through a per-vertex valid mask. When the required vertex count is reached, the block presents a completed primitive through a valid/accept handshake. In strip mode, poly-lines and strips shift the vertex window after each accepted primitive, so each new primitive needs only one further vertex load.

---
 rtl/gpu_vtxload_pkg.sv | 29 ++
 rtl/gpu_vtx_color_conv.sv | 14 +
 rtl/gpu_vertex_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_gpu_vertex_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_vtxload_pkg.sv
// Shared types, constants and colour conversion for the vertex loader.
package gpu_vtxload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  localparam logic [8:0] COL_WHITE = 9'd256;

  // 8-bit component to 9-bit rasterizer colour; textured colours are doubled,
  // untextured non-fill colours are biased by their MSB so 0xFF reaches 256.
  function automatic logic [8:0] color_conv(input logic [7:0] c,
                                            input logic       use_tex,
                                            input logic       ignore,
                                            input logic       is_fill);
    logic [8:0] r;
    if (ignore) begin
      r = COL_WHITE;
    end else if (use_tex) begin
      r = {c, 1'b0};
    end else begin
      r = {1'b0, c} + 9'(c[7] & ~is_fill);
    end
    return r;
  endfunction

endpackage

// File: rtl/gpu_vtx_color_conv.sv
// Combinational single-component colour converter.
module gpu_vtx_color_conv
  import gpu_vtxload_pkg::*;
(
  input  logic [7:0] i_comp,
  input  logic       i_bUseTexture,
  input  logic       i_bIgnoreColor,
  input  logic       i_bIsFill,
  output logic [8:0] o_col_c
);

  assign o_col_c = color_conv(i_comp, i_bUseTexture, i_bIgnoreColor, i_bIsFill);

endmodule

// File: rtl/gpu_vertex_loader.sv
// Vertex register file: fills slots from parser words, presents complete
// primitives to rasterizer setup, and slides the window in strip mode.
module gpu_vertex_loader
  import gpu_vtxload_pkg::*;
#(
  parameter int unsigned NUM_VTX = 4,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned COL_W   = 9,
  parameter int unsigned UV_W    = 8,
  parameter int unsigned SW      = $clog2(NUM_VTX)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [SW:0]                 i_required,
  input  logic                        i_stripMode,
  input  logic                        i_end,
  input  logic                        i_validData,
  input  logic [31:0]                 i_data,
  input  logic                        i_loadXY,
  input  logic                        i_loadUV,
  input  logic                        i_loadRGB,
  input  logic                        i_loadAllRGB,
  input  logic                        i_bUseTexture,
  input  logic                        i_bIgnoreColor,
  input  logic                        i_bIsFill,
  input  logic signed [10:0]          i_offsetX,
  input  logic signed [10:0]          i_offsetY,
  output logic                        o_loadReady,
  output logic                        o_primValid,
  input  logic                        i_primAccept,
  output logic [NUM_VTX-1:0]          o_vtxMask,
  output logic [NUM_VTX*COORD_W-1:0]  o_X,
  output logic [NUM_VTX*COORD_W-1:0]  o_Y,
  output logic [NUM_VTX*COL_W-1:0]    o_R,
  output logic [NUM_VTX*COL_W-1:0]    o_G,
  output logic [NUM_VTX*COL_W-1:0]    o_B,
  output logic [NUM_VTX*UV_W-1:0]     o_U,
  output logic [NUM_VTX*UV_W-1:0]     o_V
);

  localparam int unsigned EXT_W = COORD_W - 11;

  state_e               state_q;
  logic [NUM_VTX-1:0]   mask_q;
  logic [SW:0]          req_q;
  logic                 strip_q;
  logic [SW-1:0]        last_q;
  logic                 valid_q;
  logic                 ready_q;

  logic [COORD_W-1:0]   x_q [NUM_VTX];
  logic [COORD_W-1:0]   y_q [NUM_VTX];
  logic [COL_W-1:0]     r_q [NUM_VTX];
  logic [COL_W-1:0]     g_q [NUM_VTX];
  logic [COL_W-1:0]     b_q [NUM_VTX];
  logic [UV_W-1:0]      u_q [NUM_VTX];
  logic [UV_W-1:0]      v_q [NUM_VTX];

  logic [SW-1:0]        next_slot;
  logic [NUM_VTX-1:0]   mask_set;
  logic [NUM_VTX-1:0]   strip_mask;
  logic [SW:0]          pop_cnt;
  logic [COORD_W-1:0]   xy_x;
  logic [COORD_W-1:0]   xy_y;
  logic [8:0]           col_r;
  logic [8:0]           col_g;
  logic [8:0]           col_b;
  logic                 unused_data;

  assign unused_data = ^i_data[31:27];

  // Lowest free slot, the mask after an XY write, its in-range popcount, and
  // the mask left behind by a strip shift.
  always_comb begin
    next_slot  = '0;
    mask_set   = mask_q;
    strip_mask = '0;
    pop_cnt    = '0;
    for (int k = int'(NUM_VTX) - 1; k >= 0; k--) begin
      if (!mask_q[k]) next_slot = SW'(k);
    end
    mask_set[next_slot] = 1'b1;
    for (int k = 0; k < int'(NUM_VTX); k++) begin
      if (mask_set[k] && ((SW+1)'(k) < req_q)) pop_cnt = pop_cnt + (SW+1)'(1);
      if ((SW+1)'(k + 1) < req_q) strip_mask[k] = 1'b1;
    end
  end

  assign xy_x = {{EXT_W{i_data[10]}}, i_data[10:0]} + {{EXT_W{i_offsetX[10]}}, i_offsetX};
  assign xy_y = {{EXT_W{i_data[26]}}, i_data[26:16]} + {{EXT_W{i_offsetY[10]}}, i_offsetY};

  gpu_vtx_color_conv u_conv_r (
    .i_comp         (i_data[7:0]),
    .i_bUseTexture  (i_bUseTexture),
    .i_bIgnoreColor (i_bIgnoreColor),
    .i_bIsFill      (i_bIsFill),
    .o_col_c        (col_r)
  );

  gpu_vtx_color_conv u_conv_g (
    .i_comp         (i_data[15:8]),
    .i_bUseTexture  (i_bUseTexture),
    .i_bIgnoreColor (i_bIgnoreColor),
    .i_bIsFill      (i_bIsFill),
    .o_col_c        (col_g)
  );

  gpu_vtx_color_conv u_conv_b (
    .i_comp         (i_data[23:16]),
    .i_bUseTexture  (i_bUseTexture),
    .i_bIgnoreColor (i_bIgnoreColor),
    .i_bIsFill      (i_bIsFill),
    .o_col_c        (col_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      req_q   <= '0;
      strip_q <= 1'b0;
      last_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      for (int k = 0; k < int'(NUM_VTX); k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        r_q[k] <= '0;
        g_q[k] <= '0;
        b_q[k] <= '0;
        u_q[k] <= '0;
        v_q[k] <= '0;
      end
    end else if (i_start) begin
      state_q <= ST_LOAD;
      mask_q  <= '0;
      req_q   <= i_required;
      strip_q <= i_stripMode;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (i_end) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
          end else if (i_validData) begin
            if (i_loadAllRGB) begin
              for (int k = 0; k < int'(NUM_VTX); k++) begin
                r_q[k] <= COL_W'(col_r);
                g_q[k] <= COL_W'(col_g);
                b_q[k] <= COL_W'(col_b);
              end
            end else if (i_loadRGB) begin
              r_q[next_slot] <= COL_W'(col_r);
              g_q[next_slot] <= COL_W'(col_g);
              b_q[next_slot] <= COL_W'(col_b);
            end
            if (i_loadUV) begin
              u_q[last_q] <= UV_W'(i_data[7:0]);
              v_q[last_q] <= UV_W'(i_data[15:8]);
            end
            if (i_loadXY) begin
              x_q[next_slot] <= xy_x;
              y_q[next_slot] <= xy_y;
              mask_q         <= mask_set;
              last_q         <= next_slot;
              if (pop_cnt == req_q) begin
                state_q <= ST_PRESENT;
                valid_q <= 1'b1;
                ready_q <= 1'b0;
              end
            end
          end
        end
        ST_PRESENT: begin
          if (i_primAccept) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            if (strip_q && (req_q > (SW+1)'(1))) begin
              // Slide the window down one slot; the newest vertex stays loaded.
              for (int k = 0; k < int'(NUM_VTX) - 1; k++) begin
                if ((SW+1)'(k + 1) < req_q) begin
                  x_q[k] <= x_q[k+1];
                  y_q[k] <= y_q[k+1];
                  r_q[k] <= r_q[k+1];
                  g_q[k] <= g_q[k+1];
                  b_q[k] <= b_q[k+1];
                  u_q[k] <= u_q[k+1];
                  v_q[k] <= v_q[k+1];
                end
              end
              mask_q  <= strip_mask;
              last_q  <= SW'(req_q - (SW+1)'(2));
              state_q <= ST_LOAD;
            end else begin
              mask_q  <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_loadReady = ready_q;
  assign o_primValid = valid_q;
  assign o_vtxMask   = mask_q;

  // Flatten slot registers onto the packed output buses.
  for (genvar gv = 0; gv < int'(NUM_VTX); gv++) begin : g_pack
    assign o_X[gv*COORD_W +: COORD_W] = x_q[gv];
    assign o_Y[gv*COORD_W +: COORD_W] = y_q[gv];
    assign o_R[gv*COL_W +: COL_W]     = r_q[gv];
    assign o_G[gv*COL_W +: COL_W]     = g_q[gv];
    assign o_B[gv*COL_W +: COL_W]     = b_q[gv];
    assign o_U[gv*UV_W +: UV_W]       = u_q[gv];
    assign o_V[gv*UV_W +: UV_W]       = v_q[gv];
  end

endmodule

// File: tb/tb_gpu_vertex_loader.sv
// Directed self-checking bench for gpu_vertex_loader (4 slots, 12-bit coords).
module tb_gpu_vertex_loader;

  logic               clk;
  logic               rst;
  logic               start;
  logic [2:0]         required;
  logic               strip_mode;
  logic               end_strip;
  logic               valid_data;
  logic [31:0]        data;
  logic               load_xy;
  logic               load_uv;
  logic               load_rgb;
  logic               load_all_rgb;
  logic               use_tex;
  logic               ignore_col;
  logic               is_fill;
  logic signed [10:0] off_x;
  logic signed [10:0] off_y;
  logic               load_ready;
  logic               prim_valid;
  logic               prim_accept;
  logic [3:0]         vtx_mask;
  logic [47:0]        o_x;
  logic [47:0]        o_y;
  logic [35:0]        o_r;
  logic [35:0]        o_g;
  logic [35:0]        o_b;
  logic [31:0]        o_u;
  logic [31:0]        o_v;

  int checks = 0;
  int errors = 0;

  gpu_vertex_loader dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_required     (required),
    .i_stripMode    (strip_mode),
    .i_end          (end_strip),
    .i_validData    (valid_data),
    .i_data         (data),
    .i_loadXY       (load_xy),
    .i_loadUV       (load_uv),
    .i_loadRGB      (load_rgb),
    .i_loadAllRGB   (load_all_rgb),
    .i_bUseTexture  (use_tex),
    .i_bIgnoreColor (ignore_col),
    .i_bIsFill      (is_fill),
    .i_offsetX      (off_x),
    .i_offsetY      (off_y),
    .o_loadReady    (load_ready),
    .o_primValid    (prim_valid),
    .i_primAccept   (prim_accept),
    .o_vtxMask      (vtx_mask),
    .o_X            (o_x),
    .o_Y            (o_y),
    .o_R            (o_r),
    .o_G            (o_g),
    .o_B            (o_b),
    .o_U            (o_u),
    .o_V            (o_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] gx(input int k);
    return o_x[k*12 +: 12];
  endfunction

  function automatic logic [11:0] gy(input int k);
    return o_y[k*12 +: 12];
  endfunction

  function automatic logic [8:0] gr(input int k);
    return o_r[k*9 +: 9];
  endfunction

  function automatic logic [8:0] gg(input int k);
    return o_g[k*9 +: 9];
  endfunction

  function automatic logic [8:0] gb(input int k);
    return o_b[k*9 +: 9];
  endfunction

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [2:0] req, input logic strip);
    start = 1'b1; required = req; strip_mode = strip;
    step();
    start = 1'b0;
  endtask

  task automatic do_xy(input logic [10:0] x, input logic [10:0] y);
    data = {5'd0, y, 5'd0, x}; valid_data = 1'b1; load_xy = 1'b1;
    step();
    valid_data = 1'b0; load_xy = 1'b0;
  endtask

  task automatic do_rgb(input logic [31:0] d, input logic all);
    data = d; valid_data = 1'b1; load_rgb = ~all; load_all_rgb = all;
    step();
    valid_data = 1'b0; load_rgb = 1'b0; load_all_rgb = 1'b0;
  endtask

  task automatic do_uv(input logic [15:0] d);
    data = {16'd0, d}; valid_data = 1'b1; load_uv = 1'b1;
    step();
    valid_data = 1'b0; load_uv = 1'b0;
  endtask

  task automatic do_accept();
    prim_accept = 1'b1;
    step();
    prim_accept = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; required = 3'd0; strip_mode = 1'b0; end_strip = 1'b0;
    valid_data = 1'b0; data = 32'd0; load_xy = 1'b0; load_uv = 1'b0; load_rgb = 1'b0;
    load_all_rgb = 1'b0; use_tex = 1'b0; ignore_col = 1'b0; is_fill = 1'b0;
    off_x = 11'sd0; off_y = 11'sd0; prim_accept = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_valid", 64'(prim_valid), 64'd0);
    check("rst_ready", 64'(load_ready), 64'd1);
    check("rst_mask", 64'(vtx_mask), 64'd0);
    check("rst_x", 64'(o_x), 64'd0);
    check("rst_r", 64'(o_r), 64'd0);
    check("rst_u", 64'(o_u), 64'd0);

    // Non-strip triangle with offset (5,-5)
    off_x = 11'sd5; off_y = -11'sd5;
    do_start(3'd3, 1'b0);
    check("start_mask", 64'(vtx_mask), 64'd0);
    do_rgb(32'h0080FF80, 1'b0);
    do_xy(11'd10, 11'd20);
    do_uv(16'h3412);
    check("s0_x", 64'(gx(0)), 64'h00F);
    check("s0_y", 64'(gy(0)), 64'h00F);
    check("s0_r", 64'(gr(0)), 64'h081);
    check("s0_g", 64'(gg(0)), 64'h100);
    check("s0_b", 64'(gb(0)), 64'h081);
    check("s0_u", 64'(o_u[7:0]), 64'h12);
    check("s0_v", 64'(o_v[7:0]), 64'h34);
    check("s0_mask", 64'(vtx_mask), 64'b0001);
    do_xy(11'd1, 11'd2);
    check("s1_xy", 64'({gx(1), gy(1)}), 64'h006FFD);
    check("two_valid", 64'(prim_valid), 64'd0);
    do_xy(11'd3, 11'd4);
    check("tri_valid", 64'(prim_valid), 64'd1);
    check("tri_ready", 64'(load_ready), 64'd0);
    check("tri_mask", 64'(vtx_mask), 64'b0111);
    check("s2_xy", 64'({gx(2), gy(2)}), 64'h008FFF);
    do_xy(11'd100, 11'd100);
    check("drop_x", 64'(o_x), {16'd0, 12'h000, 12'h008, 12'h006, 12'h00F});
    check("drop_mask", 64'(vtx_mask), 64'b0111);
    check("hold_valid", 64'(prim_valid), 64'd1);
    do_accept();
    check("acc_valid", 64'(prim_valid), 64'd0);
    check("acc_mask", 64'(vtx_mask), 64'd0);
    check("acc_ready", 64'(load_ready), 64'd1);

    // Poly-line strip, two vertices per primitive
    off_x = 11'sd0; off_y = 11'sd0;
    do_start(3'd2, 1'b1);
    do_xy(11'd1, 11'd1);
    check("pl_a_valid", 64'(prim_valid), 64'd0);
    do_xy(11'd2, 11'd2);
    check("pl_ab_valid", 64'(prim_valid), 64'd1);
    do_accept();
    check("pl_shift_x0", 64'(gx(0)), 64'h002);
    check("pl_shift_mask", 64'(vtx_mask), 64'b0001);
    check("pl_shift_ready", 64'(load_ready), 64'd1);
    do_xy(11'd3, 11'd3);
    check("pl_bc_valid", 64'(prim_valid), 64'd1);
    check("pl_bc_x", 64'({gx(0), gx(1)}), 64'h002003);
    do_accept();
    check("pl_shift2_x0", 64'(gx(0)), 64'h003);
    end_strip = 1'b1;
    step();
    end_strip = 1'b0;
    check("pl_end_mask", 64'(vtx_mask), 64'd0);
    check("pl_end_ready", 64'(load_ready), 64'd1);

    // Colour conversion rules
    do_start(3'd4, 1'b0);
    use_tex = 1'b1;
    do_rgb(32'h00000080, 1'b0);
    check("col_tex", 64'({gr(0), gg(0)}), {46'd0, 9'h100, 9'h000});
    use_tex = 1'b0; is_fill = 1'b1;
    do_rgb(32'h000000FF, 1'b0);
    check("col_fill", 64'(gr(0)), 64'h0FF);
    is_fill = 1'b0; ignore_col = 1'b1;
    do_rgb(32'h00123456, 1'b0);
    check("col_ignore", 64'({gr(0), gg(0), gb(0)}), {37'd0, 9'h100, 9'h100, 9'h100});
    ignore_col = 1'b0;
    do_rgb(32'h00102030, 1'b1);
    check("col_all_r", 64'(o_r), {28'd0, 9'h030, 9'h030, 9'h030, 9'h030});
    check("col_all_b", 64'(o_b), {28'd0, 9'h010, 9'h010, 9'h010, 9'h010});
    check("col_mask", 64'(vtx_mask), 64'd0);

    // Coordinate wrap in 12 bits
    off_x = 11'h3FF;
    do_xy(11'h3FF, 11'd0);
    check("wrap_pos", 64'(gx(0)), 64'h7FE);
    off_x = 11'h400;
    do_xy(11'h400, 11'd0);
    check("wrap_neg", 64'(gx(1)), 64'h800);
    check("wrap_mask", 64'(vtx_mask), 64'b0011);

    // i_start overrides accept and load data
    off_x = 11'sd0;
    do_start(3'd2, 1'b1);
    do_xy(11'd7, 11'd7);
    do_xy(11'd9, 11'd9);
    check("ms_valid", 64'(prim_valid), 64'd1);
    start = 1'b1; prim_accept = 1'b1;
    step();
    start = 1'b0; prim_accept = 1'b0;
    check("ms_valid_clr", 64'(prim_valid), 64'd0);
    check("ms_mask", 64'(vtx_mask), 64'd0);
    check("ms_noshift", 64'(gx(0)), 64'h007);
    start = 1'b1; valid_data = 1'b1; load_xy = 1'b1; data = {5'd0, 11'd5, 5'd0, 11'd5};
    step();
    start = 1'b0; valid_data = 1'b0; load_xy = 1'b0;
    check("sd_mask", 64'(vtx_mask), 64'd0);
    check("sd_x0", 64'(gx(0)), 64'h007);

    // Reset while presenting
    do_xy(11'd7, 11'd7);
    do_xy(11'd9, 11'd9);
    check("mr_valid", 64'(prim_valid), 64'd1);
    rst = 1'b1; prim_accept = 1'b1;
    step();
    rst = 1'b0; prim_accept = 1'b0;
    check("mr_valid_clr", 64'(prim_valid), 64'd0);
    check("mr_mask", 64'(vtx_mask), 64'd0);
    check("mr_x", 64'(o_x), 64'd0);
    check("mr_ready", 64'(load_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
